onewire_master: RTL and testbench

ONEWIRE_MASTER -- requirements
Module: onewire_master

---
 rtl/onewire_master.sv | 168 ++++++++++++++++
 tb/tb_onewire_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_master.sv
// 1-Wire bus master: bus reset/presence detect, byte write and byte read, driving
// an open-drain pad through a tri-state control with all timing derived from a 1 us tick.
`timescale 1ns/1ps
module onewire_master #(
    parameter int CLK_PER_US = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       presence,
    output logic       dq_i,
    output logic       dq_t,
    input  logic       dq_o
);

    localparam int PW = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_REL,
        SLOT_LOW,
        SLOT_REL,
        FINISH
    } state_t;

    state_t      state_reg;
    logic [PW-1:0] pre_reg;
    logic [8:0]  us_reg;
    logic [2:0]  slot_reg;
    logic [7:0]  tx_reg;
    logic [7:0]  shift_reg;
    logic        rd_reg;
    logic [1:0]  sync_reg;

    logic        tick;
    logic        cur_bit;
    logic [8:0]  low_us;
    logic [8:0]  rel_us;

    assign tick      = (pre_reg == PW'(CLK_PER_US - 1));
    assign cur_bit   = tx_reg[slot_reg];
    // Only a write of a 0 bit stretches the low phase; reads and 1-bits use the short pulse.
    assign low_us    = (!rd_reg && !cur_bit) ? 9'd60 : 9'd6;
    assign rel_us    = 9'd70 - low_us;
    assign cmd_ready = (state_reg == IDLE);
    assign dq_i      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pre_reg   <= '0;
            us_reg    <= '0;
            slot_reg  <= '0;
            tx_reg    <= '0;
            shift_reg <= '0;
            rd_reg    <= 1'b0;
            sync_reg  <= '0;
            rx_byte   <= '0;
            done      <= 1'b0;
            presence  <= 1'b0;
            dq_t      <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], dq_o};
            done     <= 1'b0;

            // Free-running microsecond timebase; phase transitions below restart it.
            if (state_reg == IDLE) begin
                pre_reg <= '0;
                us_reg  <= '0;
            end else if (tick) begin
                pre_reg <= '0;
                us_reg  <= us_reg + 9'd1;
            end else begin
                pre_reg <= pre_reg + PW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        tx_reg   <= tx_byte;
                        rd_reg   <= (cmd == 2'b10);
                        slot_reg <= '0;
                        case (cmd)
                            2'b00: begin
                                state_reg <= RST_LOW;
                                dq_t      <= 1'b0;
                            end
                            2'b01, 2'b10: begin
                                state_reg <= SLOT_LOW;
                                dq_t      <= 1'b0;
                            end
                            default: begin
                                state_reg <= FINISH;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                RST_LOW: begin
                    if (tick && us_reg == 9'd479) begin
                        state_reg <= RST_REL;
                        dq_t      <= 1'b1;
                        pre_reg   <= '0;
                        us_reg    <= '0;
                    end
                end
                RST_REL: begin
                    if (tick) begin
                        if (us_reg == 9'd69) begin
                            presence <= ~sync_reg[1];
                        end
                        if (us_reg == 9'd479) begin
                            state_reg <= FINISH;
                            done      <= 1'b1;
                            pre_reg   <= '0;
                            us_reg    <= '0;
                        end
                    end
                end
                SLOT_LOW: begin
                    if (tick && us_reg == low_us - 9'd1) begin
                        state_reg <= SLOT_REL;
                        dq_t      <= 1'b1;
                        pre_reg   <= '0;
                        us_reg    <= '0;
                    end
                end
                SLOT_REL: begin
                    if (tick) begin
                        // 9 us into release is 15 us from the start of a read slot.
                        if (rd_reg && us_reg == 9'd8) begin
                            shift_reg[slot_reg] <= sync_reg[1];
                        end
                        if (us_reg == rel_us - 9'd1) begin
                            pre_reg <= '0;
                            us_reg  <= '0;
                            if (slot_reg == 3'd7) begin
                                state_reg <= FINISH;
                                done      <= 1'b1;
                                if (rd_reg) begin
                                    rx_byte <= shift_reg;
                                end
                            end else begin
                                slot_reg  <= slot_reg + 3'd1;
                                state_reg <= SLOT_LOW;
                                dq_t      <= 1'b0;
                            end
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    dq_t      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master: device model on the open-drain line, pulse
// widths and slot spacing measured on dq_t and compared with timings computed from the bit values.
`timescale 1ns/1ps
module tb_onewire_master;

    localparam int C    = 4;
    localparam int TCLK = 10;
    localparam int US   = C * TCLK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_byte;
    logic       done;
    logic       presence;
    logic       dq_i;
    logic       dq_t;
    logic       dq_o;

    logic       dev_pull = 1'b0;
    int         dev_mode = 0;
    logic [7:0] dev_byte = 8'h00;
    logic [2:0] dev_idx = 3'd0;
    int         pres_start = 20;
    int         pres_end = 100;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_rx = 8'h00;
    logic       exp_pres = 1'b0;

    int cyc = 0;
    int low_run = 0;
    bit prev_t = 1'b1;
    int pulses[$];
    int falls[$];
    int done_cnt = 0;

    assign dq_o = dq_t & ~dev_pull;

    always #(TCLK/2) clk = ~clk;

    onewire_master #(.CLK_PER_US(C)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .tx_byte(tx_byte), .rx_byte(rx_byte),
        .done(done), .presence(presence), .dq_i(dq_i), .dq_t(dq_t), .dq_o(dq_o)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor: low-pulse widths (in cycles), falling-edge times, done pulses.
    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (dq_t === 1'b0) begin
            if (prev_t) falls.push_back(cyc);
            low_run++;
        end else if (low_run > 0) begin
            pulses.push_back(low_run);
            low_run = 0;
        end
        prev_t = (dq_t !== 1'b0);
    end

    // Presence responder: pulls low some time after release, holds until pres_end.
    initial forever begin
        @(posedge dq_t);
        if (dev_mode == 1 && rst_n === 1'b1) begin
            #(pres_start * US);
            dev_pull = 1'b1;
            #((pres_end - pres_start) * US);
            dev_pull = 1'b0;
        end
    end

    // Read responder: holds the line low for 30 us after slot start for a 0 bit.
    initial forever begin
        @(negedge dq_t);
        if (dev_mode == 2) begin
            logic b;
            b = dev_byte[dev_idx];
            dev_idx = dev_idx + 3'd1;
            if (!b) begin
                dev_pull = 1'b1;
                #(30 * US);
                dev_pull = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] b, input bit hold,
                         output int acc, output bit ok);
        int n;
        @(negedge clk);
        cmd = c;
        tx_byte = b;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = (cmd_ready === 1'b1);
        @(negedge clk);
        acc = cyc;
        if (!hold) begin
            cmd_valid = 1'b0;
            tx_byte = 8'($urandom);
        end
    endtask

    task automatic wait_done(input int limit, output int dc, output bit ok);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1);
        dc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dq_t !== 1'b1)     begin n_fail++; $display("FAIL reset_dq_t got=%b exp=1", dq_t); end
        n_checks++; if (dq_i !== 1'b0)     begin n_fail++; $display("FAIL reset_dq_i got=%b exp=0", dq_i); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
        n_checks++; if (presence !== 1'b0) begin n_fail++; $display("FAIL reset_presence got=%b exp=0", presence); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn reset released");
    endtask

    task automatic test_bus_reset(input bit dev);
        int acc, dc, d0;
        bit ok, okd;
        dev_mode = dev ? 1 : 0;
        pres_start = $urandom_range(15, 50);
        pres_end = $urandom_range(80, 200);
        pulses.delete();
        falls.delete();
        d0 = done_cnt;
        issue(2'b00, 8'h00, 1'b0, acc, ok);
        wait_done(1000 * C, dc, okd);
        n_checks++; if (!(ok && okd)) begin n_fail++; $display("FAIL busrst_done_seen got=%b exp=1", ok && okd); end
        n_checks++; if (dc - acc !== 960 * C) begin n_fail++; $display("FAIL busrst_latency got=%0d exp=%0d", dc - acc, 960 * C); end
        exp_pres = dev;
        n_checks++; if (presence !== exp_pres) begin n_fail++; $display("FAIL busrst_presence got=%b exp=%b", presence, exp_pres); end
        n_checks++; if (rx_byte !== exp_rx) begin n_fail++; $display("FAIL busrst_rx_kept got=%h exp=%h", rx_byte, exp_rx); end
        repeat (3) @(negedge clk);
        n_checks++; if (pulses.size() !== 1) begin n_fail++; $display("FAIL busrst_pulse_count got=%0d exp=1", pulses.size()); end
        if (pulses.size() > 0) begin
            n_checks++; if (pulses[0] !== 480 * C) begin n_fail++; $display("FAIL busrst_low_width got=%0d exp=%0d", pulses[0], 480 * C); end
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL busrst_done_pulses got=%0d exp=1", done_cnt - d0); end
        dev_mode = 0;
        $display("txn bus_reset dev=%0d presence=%b latency=%0d", dev, presence, dc - acc);
    endtask

    task automatic test_write(input logic [7:0] b);
        int acc, dc, d0;
        bit ok, okd;
        dev_mode = 0;
        pulses.delete();
        falls.delete();
        d0 = done_cnt;
        issue(2'b01, b, 1'b0, acc, ok);
        wait_done(700 * C, dc, okd);
        n_checks++; if (!(ok && okd)) begin n_fail++; $display("FAIL write_done_seen got=%b exp=1", ok && okd); end
        n_checks++; if (dc - acc !== 560 * C) begin n_fail++; $display("FAIL write_latency got=%0d exp=%0d", dc - acc, 560 * C); end
        repeat (3) @(negedge clk);
        n_checks++; if (pulses.size() !== 8) begin n_fail++; $display("FAIL write_pulse_count got=%0d exp=8", pulses.size()); end
        for (int i = 0; i < 8 && i < pulses.size(); i++) begin
            int e;
            e = b[i] ? 6 * C : 60 * C;
            n_checks++; if (pulses[i] !== e) begin n_fail++; $display("FAIL write_bit%0d_width got=%0d exp=%0d", i, pulses[i], e); end
        end
        for (int i = 0; i + 1 < falls.size(); i++) begin
            n_checks++; if (falls[i+1] - falls[i] !== 70 * C) begin n_fail++; $display("FAIL write_slot%0d_period got=%0d exp=%0d", i, falls[i+1] - falls[i], 70 * C); end
        end
        n_checks++; if (rx_byte !== exp_rx) begin n_fail++; $display("FAIL write_rx_kept got=%h exp=%h", rx_byte, exp_rx); end
        n_checks++; if (presence !== exp_pres) begin n_fail++; $display("FAIL write_presence_kept got=%b exp=%b", presence, exp_pres); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL write_done_pulses got=%0d exp=1", done_cnt - d0); end
        $display("txn write byte=%h pulses=%0d latency=%0d", b, pulses.size(), dc - acc);
    endtask

    task automatic test_read(input logic [7:0] d);
        int acc, dc;
        bit ok, okd;
        dev_mode = 2;
        dev_byte = d;
        dev_idx = 3'd0;
        pulses.delete();
        falls.delete();
        issue(2'b10, 8'($urandom), 1'b0, acc, ok);
        wait_done(700 * C, dc, okd);
        exp_rx = d;
        n_checks++; if (!(ok && okd)) begin n_fail++; $display("FAIL read_done_seen got=%b exp=1", ok && okd); end
        n_checks++; if (dc - acc !== 560 * C) begin n_fail++; $display("FAIL read_latency got=%0d exp=%0d", dc - acc, 560 * C); end
        n_checks++; if (rx_byte !== exp_rx) begin n_fail++; $display("FAIL read_rx_byte got=%h exp=%h", rx_byte, exp_rx); end
        n_checks++; if (presence !== exp_pres) begin n_fail++; $display("FAIL read_presence_kept got=%b exp=%b", presence, exp_pres); end
        repeat (3) @(negedge clk);
        n_checks++; if (pulses.size() !== 8) begin n_fail++; $display("FAIL read_pulse_count got=%0d exp=8", pulses.size()); end
        for (int i = 0; i < pulses.size(); i++) begin
            n_checks++; if (pulses[i] !== 6 * C) begin n_fail++; $display("FAIL read_slot%0d_width got=%0d exp=%0d", i, pulses[i], 6 * C); end
        end
        dev_mode = 0;
        $display("txn read dev=%h rx_byte=%h", d, rx_byte);
    endtask

    task automatic test_reserved();
        int acc, dc, d0;
        bit ok, okd;
        pulses.delete();
        falls.delete();
        d0 = done_cnt;
        issue(2'b11, 8'($urandom), 1'b0, acc, ok);
        wait_done(5, dc, okd);
        n_checks++; if (!(ok && okd)) begin n_fail++; $display("FAIL rsvd_done_seen got=%b exp=1", ok && okd); end
        n_checks++; if (dc - acc !== 0) begin n_fail++; $display("FAIL rsvd_latency got=%0d exp=0", dc - acc); end
        repeat (4) @(negedge clk);
        n_checks++; if (falls.size() !== 0) begin n_fail++; $display("FAIL rsvd_bus_quiet got=%0d exp=0", falls.size()); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rsvd_done_pulses got=%0d exp=1", done_cnt - d0); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rsvd_ready got=%b exp=1", cmd_ready); end
        $display("txn reserved latency=%0d", dc - acc);
    endtask

    task automatic test_back_to_back(input logic [7:0] b);
        int acc, d1, d2, d0;
        bit ok, ok1, ok2;
        dev_mode = 0;
        pulses.delete();
        falls.delete();
        d0 = done_cnt;
        issue(2'b01, b, 1'b1, acc, ok);
        cmd = 2'b11;
        tx_byte = ~b;
        wait_done(700 * C, d1, ok1);
        @(negedge clk);
        wait_done(6, d2, ok2);
        cmd_valid = 1'b0;
        n_checks++; if (!(ok && ok1 && ok2)) begin n_fail++; $display("FAIL b2b_done_seen got=%b exp=1", ok && ok1 && ok2); end
        n_checks++; if (d1 - acc !== 560 * C) begin n_fail++; $display("FAIL b2b_write_latency got=%0d exp=%0d", d1 - acc, 560 * C); end
        n_checks++; if (d2 - d1 !== 2) begin n_fail++; $display("FAIL b2b_second_accept got=%0d exp=2", d2 - d1); end
        repeat (4) @(negedge clk);
        n_checks++; if (pulses.size() !== 8) begin n_fail++; $display("FAIL b2b_pulse_count got=%0d exp=8", pulses.size()); end
        for (int i = 0; i < 8 && i < pulses.size(); i++) begin
            int e;
            e = b[i] ? 6 * C : 60 * C;
            n_checks++; if (pulses[i] !== e) begin n_fail++; $display("FAIL b2b_bit%0d_width got=%0d exp=%0d", i, pulses[i], e); end
        end
        n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt - d0); end
        $display("txn back_to_back byte=%h then reserved gap=%0d", b, d2 - d1);
    endtask

    task automatic test_abort();
        int acc, n, d0;
        bit ok;
        dev_mode = 0;
        pulses.delete();
        falls.delete();
        issue(2'b01, 8'hA5, 1'b0, acc, ok);
        n = 0;
        while (falls.size() < 4 && n < 400 * C) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (dq_t !== 1'b0) begin n_fail++; $display("FAIL abort_slot3_low got=%b exp=0", dq_t); end
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dq_t !== 1'b1) begin n_fail++; $display("FAIL abort_release got=%b exp=1", dq_t); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        repeat (5) @(negedge clk);
        exp_pres = 1'b0;
        exp_rx = 8'h00;
        n_checks++; if (presence !== exp_pres) begin n_fail++; $display("FAIL abort_presence_clr got=%b exp=%b", presence, exp_pres); end
        n_checks++; if (rx_byte !== exp_rx) begin n_fail++; $display("FAIL abort_rx_clr got=%h exp=%h", rx_byte, exp_rx); end
        rst_n = 1'b1;
        repeat (600 * C) @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        n_checks++; if (dq_t !== 1'b1) begin n_fail++; $display("FAIL abort_bus_idle got=%b exp=1", dq_t); end
        $display("txn abort during slot 3 of write A5");
    endtask

    initial begin
        test_reset();
        test_bus_reset(1'b1);
        test_write(8'hA5);
        test_write(8'($urandom));
        test_read(8'h3C);
        test_read(8'($urandom));
        test_bus_reset(1'b0);
        test_reserved();
        test_back_to_back(8'($urandom));
        test_abort();
        test_reserved();
        test_write(8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
